// File: rtl/wb_slave_mux.sv
// wb_slave_mux: shares one Wishbone slave port between NSLV downstream peripherals.
//
// The block decodes the host address, forwards one transaction at a time to the
// selected slot, and returns registered data and ack to the host. Accesses outside
// the window and slots that never ack still complete. They return ERR_WORD, raise a
// one-cycle err_irq_o and bump a saturating error counter.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_cyc/stb/we/sel/adr/dat_i  host request
//   wbs_ack_o, wbs_dat_o      host response (registered)
//   s_cyc_o, s_stb_o          one-hot per-slave cycle/strobe
//   s_we/sel/adr/dat_o        shared request fields, latched at acceptance
//   s_dat_i, s_ack_i          slave read data (slot k = bits [32k+31:32k]) and acks
//   err_irq_o, err_cnt_o      miss/timeout pulse and saturating error count
module wb_slave_mux #(
    parameter int          NSLV     = 4,
    parameter logic [7:0]  BASE_HI  = 8'h30,
    parameter int          SLOT_LSB = 16,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [NSLV-1:0]     s_cyc_o,
    output logic [NSLV-1:0]     s_stb_o,
    output logic                s_we_o,
    output logic [3:0]          s_sel_o,
    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    input  logic [32*NSLV-1:0]  s_dat_i,
    input  logic [NSLV-1:0]     s_ack_i,
    output logic                err_irq_o,
    output logic [7:0]          err_cnt_o
);

    localparam int         SW       = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [SW-1:0]   slot_r, slot_s, adr_slot_s;
    logic [7:0]      cnt_r, cnt_s;
    logic            served_r, served_s;
    logic            hit_s, req_s;
    logic [NSLV-1:0] onehot_s;
    logic            sel_ack_s;
    logic [31:0]     sel_dat_s;

    // Next values of the registered outputs
    logic [NSLV-1:0] cyc_s, stb_s;
    logic            we_s;
    logic [3:0]      sel_s;
    logic [31:0]     adr_s, wdat_s, rdat_s;
    logic            ack_s, irq_s;
    logic [7:0]      err_cnt_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decode the host request and select the active slot's response lines
    always_comb begin
        adr_slot_s = wbs_adr_i[SLOT_LSB +: SW];
        hit_s      = (wbs_adr_i[31:24] == BASE_HI) && (int'(adr_slot_s) < NSLV);
        onehot_s   = NSLV'(1) << adr_slot_s;
        // served_r blocks re-acceptance of a request the host keeps asserting
        // after it has already been answered
        req_s      = wbs_cyc_i && wbs_stb_i && !served_r;
        sel_ack_s  = s_ack_i[slot_r];
        sel_dat_s  = s_dat_i[int'(slot_r) * 32 +: 32];
    end

    // Next-state and next-output logic of the transaction FSM
    always_comb begin
        state_s   = state_r;
        slot_s    = slot_r;
        cnt_s     = cnt_r;
        served_s  = wbs_stb_i ? served_r : 1'b0;
        cyc_s     = s_cyc_o;
        stb_s     = s_stb_o;
        we_s      = s_we_o;
        sel_s     = s_sel_o;
        adr_s     = s_adr_o;
        wdat_s    = s_dat_o;
        rdat_s    = wbs_dat_o;
        irq_s     = 1'b0;
        err_cnt_s = err_cnt_o;
        // The host ack is registered from RESP, so it appears one cycle after
        // the FSM enters RESP, while the response data is already stable.
        ack_s     = (state_r == RESP);

        case (state_r)
            IDLE: begin
                if (req_s) begin
                    served_s = 1'b1;
                    we_s     = wbs_we_i;
                    sel_s    = wbs_sel_i;
                    adr_s    = wbs_adr_i;
                    wdat_s   = wbs_dat_i;
                    if (hit_s) begin
                        cyc_s   = onehot_s;
                        stb_s   = onehot_s;
                        slot_s  = adr_slot_s;
                        cnt_s   = 8'd0;
                        state_s = BUSY;
                    end else begin
                        rdat_s    = ERR_WORD;
                        irq_s     = 1'b1;
                        err_cnt_s = sat_inc(err_cnt_o);
                        state_s   = RESP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (!wbs_cyc_i) begin
                    // Host abort: silent return, no ack and no error
                    cyc_s   = '0;
                    stb_s   = '0;
                    state_s = IDLE;
                end else if (sel_ack_s) begin
                    // A real ack takes priority over a timeout in the same cycle
                    rdat_s  = sel_dat_s;
                    cyc_s   = '0;
                    stb_s   = '0;
                    state_s = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    rdat_s    = ERR_WORD;
                    irq_s     = 1'b1;
                    err_cnt_s = sat_inc(err_cnt_o);
                    cyc_s     = '0;
                    stb_s     = '0;
                    state_s   = RESP;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                cyc_s   = '0;
                stb_s   = '0;
                state_s = IDLE;
            end
        endcase
    end

    // State, bookkeeping and output registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r   <= IDLE;
            slot_r    <= '0;
            cnt_r     <= 8'd0;
            served_r  <= 1'b0;
            s_cyc_o   <= '0;
            s_stb_o   <= '0;
            s_we_o    <= 1'b0;
            s_sel_o   <= 4'd0;
            s_adr_o   <= 32'd0;
            s_dat_o   <= 32'd0;
            wbs_dat_o <= 32'd0;
            wbs_ack_o <= 1'b0;
            err_irq_o <= 1'b0;
            err_cnt_o <= 8'd0;
        end else begin
            state_r   <= state_s;
            slot_r    <= slot_s;
            cnt_r     <= cnt_s;
            served_r  <= served_s;
            s_cyc_o   <= cyc_s;
            s_stb_o   <= stb_s;
            s_we_o    <= we_s;
            s_sel_o   <= sel_s;
            s_adr_o   <= adr_s;
            s_dat_o   <= wdat_s;
            wbs_dat_o <= rdat_s;
            wbs_ack_o <= ack_s;
            err_irq_o <= irq_s;
            err_cnt_o <= err_cnt_s;
        end
    end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Self-checking bench for wb_slave_mux (NSLV=4, TIMEOUT=8).
// Table-driven single transactions with a response scoreboard, followed by
// hand-written sequences for held requests, host abort, reset in BUSY and
// error-counter saturation.
module tb_wb_slave_mux;
    localparam int NSLV = 4;
    localparam int TMO  = 8;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i;
    logic                wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]          wbs_sel_i;
    logic [31:0]         wbs_adr_i, wbs_dat_i;
    logic                wbs_ack_o;
    logic [31:0]         wbs_dat_o;
    logic [NSLV-1:0]     s_cyc_o, s_stb_o;
    logic                s_we_o;
    logic [3:0]          s_sel_o;
    logic [31:0]         s_adr_o, s_dat_o;
    logic [32*NSLV-1:0]  s_dat_i;
    logic [NSLV-1:0]     s_ack_i;
    logic                err_irq_o;
    logic [7:0]          err_cnt_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_slave_mux #(
        .NSLV(NSLV), .BASE_HI(8'h30), .SLOT_LSB(16), .TIMEOUT(TMO), .ERR_WORD(32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .err_irq_o(err_irq_o), .err_cnt_o(err_cnt_o)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          ack_at;   // strobed cycle on which the target acks, 0 = never
        logic [31:0] rdat;     // data the target slave drives
        int          spur;     // slot driving a spurious ack while strobed, -1 = none
        logic [3:0]  exp_stb;  // expected one-hot strobe
        int          exp_nstb; // expected number of strobed cycles
        int          exp_lat;  // expected ack cycle, request cycle = 0
        logic [31:0] exp_dat;
        int          exp_err;  // expected irq pulses
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[8];
    vec_t miss_v;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_errs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bump_err();
        if (exp_errs < 255) exp_errs++;
    endtask

    task automatic idle_host();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    endtask

    task automatic run_vec(input vec_t v);
        int   tslot;
        int   strobed;
        int   irqs;
        int   ack_k;
        sb_t  e;
        tslot = int'(v.adr[17:16]);
        for (int i = 0; i < NSLV; i++) s_dat_i[32*i +: 32] = 32'hF0F0_0000 | 32'(i);
        s_dat_i[32*tslot +: 32] = v.rdat;
        s_ack_i = '0;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = v.we;
        wbs_sel_i = v.sel; wbs_adr_i = v.adr; wbs_dat_i = v.wdat;
        e.data = v.exp_dat; e.lat = v.exp_lat;
        sb_q.push_back(e);
        strobed = 0; irqs = 0; ack_k = 0;
        for (int k = 1; k <= 40 && ack_k == 0; k++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            s_ack_i = '0;
            if (k == 1) begin
                check("s_stb_first", s_stb_o, v.exp_stb);
                check("s_cyc_first", s_cyc_o, v.exp_stb);
                check("s_adr", s_adr_o, v.adr);
                check("s_we", s_we_o, v.we);
                check("s_sel", s_sel_o, v.sel);
                check("s_dat", s_dat_o, v.wdat);
            end
            if (err_irq_o) irqs++;
            if (s_stb_o != '0) begin
                strobed++;
                if (v.ack_at == strobed) s_ack_i[tslot] = 1'b1;
                if (v.spur >= 0) s_ack_i[v.spur] = 1'b1;
            end
            if (wbs_ack_o) begin
                ack_k = k;
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL ack_unexpected: ack with empty scoreboard at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("rdata", wbs_dat_o, e.data);
                    check("latency", ack_k, e.lat);
                end
            end
        end
        s_ack_i = '0;
        if (ack_k == 0) begin
            n_checks++; n_fail++;
            $display("FAIL no_ack: got none within 40 cycles, required one for adr 0x%0h", v.adr);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
        check("strobe_cycles", strobed, v.exp_nstb);
        check("irq_pulses", irqs, v.exp_err);
        if (v.exp_err != 0) bump_err();
        check("err_cnt", err_cnt_o, exp_errs);
        idle_host();
        @(negedge wb_clk_i);
        check("ack_one_cycle", wbs_ack_o, 1'b0);
    endtask

    initial begin
        int acks;
        int irqs;
        vecs[0] = '{32'h3001_0004, 1'b0, 4'hF,    32'h0000_0000, 1, 32'h1234_5678, -1, 4'b0010, 1,  3,  32'h1234_5678, 0};
        vecs[1] = '{32'h3003_0000, 1'b1, 4'b0011, 32'hA5A5_0001, 1, 32'hCAFE_0003, -1, 4'b1000, 1,  3,  32'hCAFE_0003, 0};
        vecs[2] = '{32'h2000_0000, 1'b0, 4'hF,    32'h0000_0000, 0, 32'h0000_0000, -1, 4'b0000, 0,  2,  32'hDEAD_BEEF, 1};
        vecs[3] = '{32'h3002_0000, 1'b0, 4'hF,    32'h0000_0000, 0, 32'h0000_0000, -1, 4'b0100, 8,  10, 32'hDEAD_BEEF, 1};
        vecs[4] = '{32'h3002_0008, 1'b0, 4'hF,    32'h0000_0000, 8, 32'h5A5A_0008, -1, 4'b0100, 8,  10, 32'h5A5A_0008, 0};
        vecs[5] = '{32'h3003_0010, 1'b0, 4'hF,    32'h0000_0000, 3, 32'h3333_0003,  0, 4'b1000, 3,  5,  32'h3333_0003, 0};
        vecs[6] = '{32'h3000_0020, 1'b1, 4'b1100, 32'h0000_BEEF, 2, 32'h0000_0C0C, -1, 4'b0001, 2,  4,  32'h0000_0C0C, 0};
        vecs[7] = '{32'h3100_0000, 1'b0, 4'hF,    32'h0000_0000, 0, 32'h0000_0000, -1, 4'b0000, 0,  2,  32'hDEAD_BEEF, 1};
        miss_v  = vecs[2];

        idle_host();
        s_ack_i = '0;
        s_dat_i = '0;
        wb_rst_i = 1'b1;
        #1;
        check("rst_ack", wbs_ack_o, 1'b0);
        check("rst_stb", s_stb_o, 4'b0000);
        check("rst_err_cnt", err_cnt_o, 8'd0);
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Miss held across RESP: must be answered exactly once
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h2000_0000;
        acks = 0; irqs = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (wbs_ack_o) acks++;
            if (err_irq_o) irqs++;
        end
        bump_err();
        check("held_acks", acks, 1);
        check("held_irqs", irqs, 1);
        check("held_err_cnt", err_cnt_o, exp_errs);
        idle_host();

        // Host abort on the 3rd BUSY cycle
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3001_0000;
        repeat (3) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
        end
        check("abort_stb_before", s_stb_o, 4'b0010);
        idle_host();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("abort_stb_after", s_stb_o, 4'b0000);
        check("abort_cyc_after", s_cyc_o, 4'b0000);
        acks = 0; irqs = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (wbs_ack_o) acks++;
            if (err_irq_o) irqs++;
        end
        check("abort_acks", acks, 0);
        check("abort_irqs", irqs, 0);
        check("abort_err_cnt", err_cnt_o, exp_errs);

        // Asynchronous reset while BUSY
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0000; wbs_dat_i = 32'h1111_2222;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rstbusy_stb_before", s_stb_o, 4'b0001);
        @(posedge wb_clk_i);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("rstbusy_stb", s_stb_o, 4'b0000);
        check("rstbusy_cyc", s_cyc_o, 4'b0000);
        check("rstbusy_adr", s_adr_o, 32'h0);
        check("rstbusy_sdat", s_dat_o, 32'h0);
        check("rstbusy_we", s_we_o, 1'b0);
        check("rstbusy_wbs_dat", wbs_dat_o, 32'h0);
        check("rstbusy_err_cnt", err_cnt_o, 8'd0);
        exp_errs = 0;
        idle_host();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (wbs_ack_o) acks++;
        end
        check("rstbusy_acks", acks, 0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) run_vec(miss_v);
        check("err_cnt_saturated", err_cnt_o, 8'd255);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
